// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake, with
// a fixed number of wait states and a write-log port for simulation trace output.
module mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        log_valid,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // a response transfers on a rising edge where rsp_valid & rsp_ready. Only one
  // transaction is outstanding, and response outputs hold while rsp_ready is low.

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic [31:0]           pc_q;
  logic [31:0]           mem_q [DEPTH];
  logic                  rsp_valid_q;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  log_valid_q;
  logic [31:0]           log_pc_q;
  logic [31:0]           log_addr_q;
  logic [31:0]           log_data_q;

  logic                  c_we;
  logic [31:0]           c_addr;
  logic [3:0]            c_be;
  logic [31:0]           c_wdata;
  logic [31:0]           c_pc;
  logic                  c_in_range;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic [31:0]           cur_word;
  logic [31:0]           merged_d;
  logic                  enter_resp;

  // With zero wait states the commit happens on the accept edge itself, so the
  // live request fields are used in IDLE and the captured copy otherwise.
  always_comb begin
    c_we       = (state_q == S_IDLE) ? req_we    : we_q;
    c_addr     = (state_q == S_IDLE) ? req_addr  : addr_q;
    c_be       = (state_q == S_IDLE) ? req_be    : be_q;
    c_wdata    = (state_q == S_IDLE) ? req_wdata : wdata_q;
    c_pc       = (state_q == S_IDLE) ? req_pc    : pc_q;
    c_in_range = (c_addr >> (DEPTH_LOG2 + 2)) == 32'd0;
    c_idx      = c_addr[DEPTH_LOG2+1:2];
    cur_word   = mem_q[c_idx];
    merged_d   = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (c_be[i]) merged_d[8*i +: 8] = c_wdata[8*i +: 8];
    end
    enter_resp = 1'b0;
    if (state_q == S_IDLE)      enter_resp = req_valid && (WAIT_CYCLES == 0);
    else if (state_q == S_WAIT) enter_resp = (cnt_q == 4'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      pc_q        <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      log_valid_q <= 1'b0;
      log_pc_q    <= 32'd0;
      log_addr_q  <= 32'd0;
      log_data_q  <= 32'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      log_valid_q <= 1'b0;
      if (enter_resp) begin
        state_q     <= S_RESP;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= !c_in_range;
        rsp_rdata_q <= (!c_we && c_in_range) ? cur_word : 32'd0;
        if (c_we && c_in_range) mem_q[c_idx] <= merged_d;
        if (c_we && c_in_range && (c_be != 4'd0)) begin
          log_valid_q <= 1'b1;
          log_pc_q    <= c_pc;
          log_addr_q  <= {c_addr[31:2], 2'b00};
          log_data_q  <= merged_d;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            be_q    <= req_be;
            wdata_q <= req_wdata;
            pc_q    <= req_pc;
            if (WAIT_CYCLES != 0) begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_CYCLES);
            end
          end
        end
        S_WAIT: cnt_q <= cnt_q - 4'd1;
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // req_ready is gated by reset so it reads 0 while held and 1 right after release.
  assign req_ready = (state_q == S_IDLE) && reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign log_valid = log_valid_q;
  assign log_pc    = log_pc_q;
  assign log_addr  = log_addr_q;
  assign log_data  = log_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder: a WAIT_CYCLES=2 instance with
// a full handshake driver, and a WAIT_CYCLES=0 instance streaming back-to-back.
module tb_mem_responder;

  localparam int DL  = 10;
  localparam int WC  = 2;
  localparam int DLB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic [3:0]  req_be;
  logic        req_ready, rsp_valid, rsp_err, log_valid;
  logic [31:0] rsp_rdata, log_pc, log_addr, log_data;
  logic [1:0]  dbg_state;

  logic        b_req_valid, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_log_valid;
  logic [31:0] b_rsp_rdata, b_log_pc, b_log_addr, b_log_data;
  logic [1:0]  b_dbg_state;

  mem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .req_pc(req_pc), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .log_valid(log_valid),
    .log_pc(log_pc), .log_addr(log_addr), .log_data(log_data), .dbg_state(dbg_state)
  );

  mem_responder #(.DEPTH_LOG2(DLB), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_be(b_req_be),
    .req_wdata(b_req_wdata), .req_pc(32'h0000_0b00), .rsp_valid(b_rsp_valid),
    .rsp_ready(1'b1), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .log_valid(b_log_valid), .log_pc(b_log_pc), .log_addr(b_log_addr),
    .log_data(b_log_data), .dbg_state(b_dbg_state)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] model_a [0:(1<<DL)-1];
  logic [31:0] model_b [0:(1<<DLB)-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (log_valid === 1'b1) $display("@%08h: *%08h <= %08h", log_pc, log_addr, log_data);
  end

  // One complete transaction on the main instance; starts and ends at a negedge.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input int hold, input bit early,
                     input string tag, output logic [31:0] rd_obs);
    logic [31:0] pc, exp_rd, exp_word;
    logic        in_range, exp_log;
    int          lat;
    bit          got;
    pc       = $urandom();
    in_range = addr < (32'd4 << DL);
    exp_rd   = 32'd0;
    exp_word = 32'd0;
    if (in_range) begin
      exp_word = we ? merge_bytes(model_a[addr >> 2], wdata, be) : model_a[addr >> 2];
      if (!we) exp_rd = exp_word;
      else     model_a[addr >> 2] = exp_word;
    end
    exp_log = we && in_range && (be != 4'd0);
    rd_obs  = 32'd0;

    @(negedge clk);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be;
    req_wdata = wdata; req_pc = pc; rsp_ready = early;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom()); req_addr = $urandom();
    req_be = 4'($urandom()); req_wdata = $urandom(); req_pc = $urandom();

    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid === 1'b1) got = 1;
    end
    check({tag, "_latency"}, 32'(lat), 32'(WC + 1));
    if (!got) begin
      rsp_ready = 1'b0;
      return;
    end
    rd_obs = rsp_rdata;
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, !in_range});
    check({tag, "_log_valid"}, {31'd0, log_valid}, {31'd0, exp_log});
    if (exp_log) begin
      check({tag, "_log_pc"}, log_pc, pc);
      check({tag, "_log_addr"}, log_addr, addr & 32'hFFFF_FFFC);
      check({tag, "_log_data"}, log_data, exp_word);
    end

    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = $urandom();
        @(negedge clk);
        check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_hold_err"}, {31'd0, rsp_err}, {31'd0, !in_range});
        check({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
        check({tag, "_hold_log"}, {31'd0, log_valid}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic [31:0] last_wr_addr;
  logic        b_in, b_we;
  logic [31:0] b_addr, b_exp;

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0;
    req_wdata = '0; req_pc = '0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_be = '0; b_req_wdata = '0;
    for (int i = 0; i < (1 << DL); i++) model_a[i] = '0;
    for (int i = 0; i < (1 << DLB); i++) model_b[i] = '0;
    last_wr_addr = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    #2 reset = 1'b1;
    #1 check("rel_req_ready", {31'd0, req_ready}, 32'd1);

    txn(1'b1, 32'h10, 4'hF, 32'h1234_5678, 0, 1'b0, "wr10", rd);
    txn(1'b0, 32'h10, 4'hF, 32'h0, 0, 1'b0, "rd10", rd);
    check("rd10_const", rd, 32'h1234_5678);

    txn(1'b1, 32'h20, 4'hF, 32'hAABB_CCDD, 0, 1'b0, "wr20", rd);
    txn(1'b1, 32'h22, 4'b0001, 32'h0000_0011, 1, 1'b0, "wr22", rd);
    txn(1'b0, 32'h20, 4'hF, 32'h0, 0, 1'b0, "rd20", rd);
    check("rd20_const", rd, 32'hAABB_CC11);

    txn(1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, 0, 1'b0, "wr0", rd);
    txn(1'b0, 32'h1000, 4'hF, 32'h0, 0, 1'b0, "rd_oor", rd);
    txn(1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 0, 1'b0, "wr_oor", rd);
    txn(1'b0, 32'h0, 4'hF, 32'h0, 0, 1'b0, "rd0", rd);
    check("rd0_const", rd, 32'hCAFE_F00D);

    txn(1'b0, 32'h20, 4'hF, 32'h0, 5, 1'b0, "hold5", rd);
    txn(1'b0, 32'h10, 4'hF, 32'h0, 0, 1'b1, "early", rd);
    txn(1'b1, 32'h44, 4'h0, 32'h5555_5555, 0, 1'b0, "be0", rd);

    for (int i = 0; i < 40; i++) begin
      logic        we;
      logic [31:0] addr;
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       addr = $urandom() | 32'h0000_1000;
        1, 2:    addr = last_wr_addr;
        default: addr = $urandom_range(0, 4095);
      endcase
      if (we) last_wr_addr = addr;
      txn(we, addr, 4'($urandom()), $urandom(), $urandom_range(0, 3),
          1'($urandom_range(0, 3) == 0), "rand", rd);
    end

    txn(1'b1, 32'h30, 4'hF, 32'hDEAD_BEEF, 0, 1'b0, "wr30", rd);
    txn(1'b0, 32'h30, 4'hF, 32'h0, 0, 1'b0, "rd30", rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_be = 4'hF;
    req_wdata = 32'h55AA_55AA; req_pc = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    check("midrst_rsp_rdata", rsp_rdata, 32'd0);
    check("midrst_rsp_err", {31'd0, rsp_err}, 32'd0);
    for (int i = 0; i < (1 << DL); i++) model_a[i] = '0;
    for (int i = 0; i < (1 << DLB); i++) model_b[i] = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("rel2_req_ready", {31'd0, req_ready}, 32'd1);
    txn(1'b0, 32'h8, 4'hF, 32'h0, 0, 1'b0, "rd8", rd);
    check("rd8_const", rd, 32'h0);
    txn(1'b0, 32'h30, 4'hF, 32'h0, 0, 1'b0, "rd30_cleared", rd);

    // Zero-wait instance: request held continuously, one response every 2 cycles.
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      b_we   = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      b_addr = ($urandom_range(0, 5) == 0) ? ($urandom() | 32'h40) : $urandom_range(0, 63);
      b_in   = b_addr < (32'd4 << DLB);
      check("b_req_ready", {31'd0, b_req_ready}, 32'd1);
      b_req_valid = 1'b1; b_req_we = b_we; b_req_addr = b_addr;
      b_req_be = (i < 8) ? 4'hF : 4'($urandom()); b_req_wdata = $urandom();
      b_exp = 32'd0;
      if (b_in) begin
        if (b_we) model_b[b_addr >> 2] = merge_bytes(model_b[b_addr >> 2], b_req_wdata, b_req_be);
        else      b_exp = model_b[b_addr >> 2];
      end
      @(negedge clk);
      check("b_rsp_valid", {31'd0, b_rsp_valid}, 32'd1);
      check("b_busy_ready", {31'd0, b_req_ready}, 32'd0);
      check("b_rdata", b_rsp_rdata, b_exp);
      check("b_err", {31'd0, b_rsp_err}, {31'd0, !b_in});
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    @(negedge clk);
    check("b_idle_valid", {31'd0, b_rsp_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
